out_fm_tile_ld_ctrl: RTL and testbench

//  Sequencer for out_fm tile loads. Walks all (n,row,col) tiles of a layer and drives tile_base_* to the out_fm load filter.
//  Per tile, issues Tn*Tr row-burst read requests of READ_LENGTH words each.

---
 rtl/out_fm_tile_ld_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_out_fm_tile_ld_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/out_fm_tile_ld_ctrl.sv
// Tile-load sequencer for out_fm: walks every (n,row,col) tile of a layer, issues one
// row-burst read per (tn,tr) pair, counts the returned words and holds each tile until released.
module out_fm_tile_ld_ctrl #(
  parameter int unsigned AW              = 16,
  parameter int unsigned CW              = 16,
  parameter int unsigned DW              = 32,
  parameter int unsigned N               = 32,
  parameter int unsigned M               = 32,
  parameter int unsigned R               = 64,
  parameter int unsigned C               = 32,
  parameter int unsigned Tn              = 16,
  parameter int unsigned Tr              = 64,
  parameter int unsigned Tc              = 16,
  parameter int unsigned TILE_ROW_OFFSET = 2,
  parameter int unsigned OUT_FM_BASE     = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          layer_done,
  output logic [CW-1:0] tile_base_n,
  output logic [CW-1:0] tile_base_row,
  output logic [CW-1:0] tile_base_col,
  output logic          tile_start,
  output logic          rd_req,
  output logic [AW-1:0] rd_addr,
  output logic [CW-1:0] rd_len,
  input  logic          rd_ack,
  input  logic          fifo_push_tmp,
  output logic          tile_loaded,
  input  logic          tile_release,
  output logic          push_err
);

  localparam int unsigned READ_LENGTH = Tc + TILE_ROW_OFFSET;
  localparam int unsigned TILE_WORDS  = Tn * Tr * READ_LENGTH;
  localparam int unsigned WCW         = $clog2(TILE_WORDS + 1);
  localparam int unsigned XW          = 64;

  // Reject degenerate configurations at elaboration; DW and M carry no logic here.
  if (DW == 0 || M == 0 || Tn == 0 || Tr == 0 || Tc == 0 || AW > XW) begin : g_param_chk
    $error("out_fm_tile_ld_ctrl: illegal parameter set");
  end

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CFG  = 3'd1,
    LOAD = 3'd2,
    HOLD = 3'd3,
    FIN  = 3'd4
  } state_t;

  state_t         state;
  logic [CW-1:0]  tn;
  logic [CW-1:0]  tr;
  logic [WCW-1:0] word_cnt;
  logic           req_done;

  logic           push_ok;
  logic [WCW-1:0] cnt_nxt;
  logic           ack_fire;
  logic           last_req;
  logic           tr_wrap;
  logic [CW-1:0]  tn_nxt;
  logic [CW-1:0]  tr_nxt;
  logic           done_nxt;
  logic           col_more;
  logic           row_more;
  logic           n_more;

  assign rd_len = CW'(READ_LENGTH);

  // Burst start address for tile offset (dn,dr); wraps modulo 2^AW.
  function automatic logic [AW-1:0] burst_addr(
    input logic [CW-1:0] bn,
    input logic [CW-1:0] br,
    input logic [CW-1:0] bc,
    input logic [CW-1:0] dn,
    input logic [CW-1:0] dr
  );
    logic [XW-1:0] a;
    a = XW'(OUT_FM_BASE)
      + ((XW'(bn) + XW'(dn)) * XW'(R) + XW'(br) + XW'(dr)) * XW'(C)
      + XW'(bc);
    return AW'(a);
  endfunction

  // Next-cycle view of the request walk and the word count.
  always_comb begin
    push_ok  = (state == LOAD) && fifo_push_tmp && (word_cnt != WCW'(TILE_WORDS));
    cnt_nxt  = word_cnt + WCW'(push_ok);
    ack_fire = (state == LOAD) && rd_req && rd_ack;
    tr_wrap  = (tr == CW'(Tr - 1));
    last_req = tr_wrap && (tn == CW'(Tn - 1));
    tn_nxt   = tr_wrap ? tn + CW'(1) : tn;
    tr_nxt   = tr_wrap ? '0 : tr + CW'(1);
    done_nxt = req_done || (ack_fire && last_req);
    col_more = (XW'(tile_base_col) + XW'(Tc)) < XW'(C);
    row_more = (XW'(tile_base_row) + XW'(Tr)) < XW'(R);
    n_more   = (XW'(tile_base_n) + XW'(Tn)) < XW'(N);
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      busy          <= 1'b0;
      layer_done    <= 1'b0;
      tile_base_n   <= '0;
      tile_base_row <= '0;
      tile_base_col <= '0;
      tile_start    <= 1'b0;
      rd_req        <= 1'b0;
      rd_addr       <= '0;
      tile_loaded   <= 1'b0;
      push_err      <= 1'b0;
      tn            <= '0;
      tr            <= '0;
      word_cnt      <= '0;
      req_done      <= 1'b0;
    end else begin
      tile_start  <= 1'b0;
      tile_loaded <= 1'b0;
      layer_done  <= 1'b0;
      if (fifo_push_tmp && !push_ok) begin
        push_err <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (start) begin
            state         <= CFG;
            busy          <= 1'b1;
            tile_start    <= 1'b1;
            tile_base_n   <= '0;
            tile_base_row <= '0;
            tile_base_col <= '0;
          end
        end
        CFG: begin
          tn       <= '0;
          tr       <= '0;
          word_cnt <= '0;
          req_done <= 1'b0;
          rd_req   <= 1'b1;
          rd_addr  <= burst_addr(tile_base_n, tile_base_row, tile_base_col, '0, '0);
          state    <= LOAD;
        end
        LOAD: begin
          word_cnt <= cnt_nxt;
          if (ack_fire) begin
            if (last_req) begin
              rd_req   <= 1'b0;
              req_done <= 1'b1;
            end else begin
              tn      <= tn_nxt;
              tr      <= tr_nxt;
              rd_addr <= burst_addr(tile_base_n, tile_base_row, tile_base_col, tn_nxt, tr_nxt);
            end
          end
          if (done_nxt && (cnt_nxt == WCW'(TILE_WORDS))) begin
            tile_loaded <= 1'b1;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (tile_release) begin
            if (col_more) begin
              tile_base_col <= tile_base_col + CW'(Tc);
              tile_start    <= 1'b1;
              state         <= CFG;
            end else if (row_more) begin
              tile_base_col <= '0;
              tile_base_row <= tile_base_row + CW'(Tr);
              tile_start    <= 1'b1;
              state         <= CFG;
            end else if (n_more) begin
              tile_base_col <= '0;
              tile_base_row <= '0;
              tile_base_n   <= tile_base_n + CW'(Tn);
              tile_start    <= 1'b1;
              state         <= CFG;
            end else begin
              layer_done <= 1'b1;
              state      <= FIN;
            end
          end
        end
        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_out_fm_tile_ld_ctrl.sv
// Directed bench for out_fm_tile_ld_ctrl on a small 4x4x6 layer with 2x2x4 tiles.
module tb_out_fm_tile_ld_ctrl;

  localparam int NN   = 4;
  localparam int NR   = 4;
  localparam int NC   = 6;
  localparam int BASE = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy;
  logic        layer_done;
  logic [15:0] tile_base_n;
  logic [15:0] tile_base_row;
  logic [15:0] tile_base_col;
  logic        tile_start;
  logic        rd_req;
  logic [15:0] rd_addr;
  logic [15:0] rd_len;
  logic        rd_ack;
  logic        fifo_push_tmp;
  logic        tile_loaded;
  logic        tile_release;
  logic        push_err;

  int n_cmp = 0;
  int n_bad = 0;
  int n_ack = 0;
  int n_ts  = 0;
  int n_ld  = 0;
  logic [15:0] first_addr;
  logic [15:0] last_addr;

  out_fm_tile_ld_ctrl #(
    .AW(16), .CW(16), .DW(32), .N(NN), .M(32), .R(NR), .C(NC),
    .Tn(2), .Tr(2), .Tc(4), .TILE_ROW_OFFSET(2), .OUT_FM_BASE(BASE)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .layer_done(layer_done),
    .tile_base_n(tile_base_n), .tile_base_row(tile_base_row), .tile_base_col(tile_base_col),
    .tile_start(tile_start), .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len),
    .rd_ack(rd_ack), .fifo_push_tmp(fifo_push_tmp), .tile_loaded(tile_loaded),
    .tile_release(tile_release), .push_err(push_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rd_req && rd_ack) n_ack <= n_ack + 1;
    if (tile_start)       n_ts  <= n_ts + 1;
    if (layer_done)       n_ld  <= n_ld + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] exp_addr(input int n, input int row, input int col,
                                           input int tn, input int tr);
    return 16'(BASE + ((n + tn) * NR + row + tr) * NC + col);
  endfunction

  // Runs one tile from its CFG cycle until the final push has been sampled.
  task automatic load_phase(input int n, input int row, input int col, input int stall,
                            input int npush, input bit rel_in_load, input bit start_pulse);
    int k;
    int req_i;
    int pushes;
    int c;
    k = 0;
    while (tile_start !== 1'b1 && k < 10) begin
      tick();
      k++;
    end
    chk("tile_start", 64'(tile_start), 64'(1));
    chk("base_n", 64'(tile_base_n), 64'(n));
    chk("base_row", 64'(tile_base_row), 64'(row));
    chk("base_col", 64'(tile_base_col), 64'(col));
    chk("busy", 64'(busy), 64'(1));
    rd_ack = 1'b0;
    fifo_push_tmp = 1'b0;
    tick();
    req_i = 0;
    pushes = 0;
    c = 0;
    while ((req_i < 4 || pushes < npush) && c < 100) begin
      if (req_i < 4) begin
        chk("rd_req", 64'(rd_req), 64'(1));
        chk("rd_addr", 64'(rd_addr), 64'(exp_addr(n, row, col, req_i / 2, req_i % 2)));
        if (req_i == 0) first_addr = rd_addr;
        if (req_i == 3) last_addr = rd_addr;
      end else begin
        chk("rd_req_off", 64'(rd_req), 64'(0));
      end
      chk("tile_loaded_early", 64'(tile_loaded), 64'(0));
      rd_ack = (c >= stall);
      if (rd_ack && req_i < 4) req_i++;
      fifo_push_tmp = (c >= stall) && (pushes < npush);
      if (fifo_push_tmp) pushes++;
      tile_release = rel_in_load && (c == 2);
      start = start_pulse && (c == 1);
      tick();
      c++;
    end
    chk("load_bound", 64'(c < 100), 64'(1));
    fifo_push_tmp = 1'b0;
    tile_release = 1'b0;
    start = 1'b0;
  endtask

  // Releases a loaded tile either in the tile_loaded cycle or two cycles later.
  task automatic finish_tile(input bit same, input bit last);
    chk("tile_loaded", 64'(tile_loaded), 64'(1));
    chk("rd_req_hold", 64'(rd_req), 64'(0));
    if (same) begin
      tile_release = 1'b1;
      tick();
      tile_release = 1'b0;
    end else begin
      tick();
      chk("tile_loaded_pulse", 64'(tile_loaded), 64'(0));
      tick();
      tile_release = 1'b1;
      tick();
      tile_release = 1'b0;
    end
    if (last) begin
      chk("layer_done", 64'(layer_done), 64'(1));
      chk("busy_fin", 64'(busy), 64'(1));
      tick();
      chk("layer_done_pulse", 64'(layer_done), 64'(0));
      chk("busy_end", 64'(busy), 64'(0));
    end else if (same) begin
      chk("cfg_after_same", 64'(tile_start), 64'(1));
    end
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    rd_ack = 1'b0;
    fifo_push_tmp = 1'b0;
    tile_release = 1'b0;
    repeat (3) tick();
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_rd_req", 64'(rd_req), 64'(0));
    chk("rst_rd_addr", 64'(rd_addr), 64'(0));
    chk("rst_tile_start", 64'(tile_start), 64'(0));
    chk("rst_tile_loaded", 64'(tile_loaded), 64'(0));
    chk("rst_layer_done", 64'(layer_done), 64'(0));
    chk("rst_push_err", 64'(push_err), 64'(0));
    chk("rst_bases", 64'({tile_base_n, tile_base_row, tile_base_col}), 64'(0));
    chk("rd_len", 64'(rd_len), 64'(6));
    rst = 1'b1;
    tick();

    start = 1'b1;
    tick();
    start = 1'b0;
    load_phase(0, 0, 0, 0, 24, 0, 0);
    finish_tile(0, 0);
    load_phase(0, 0, 4, 0, 24, 0, 0);
    chk("addr_tile004_tn1_tr1", 64'(last_addr), 64'(134));
    finish_tile(0, 0);
    load_phase(0, 2, 0, 5, 24, 1, 0);
    finish_tile(0, 0);
    load_phase(0, 2, 4, 0, 24, 0, 0);
    finish_tile(1, 0);
    load_phase(2, 0, 0, 0, 24, 0, 1);
    chk("push_err_clean", 64'(push_err), 64'(0));
    finish_tile(0, 0);

    load_phase(2, 0, 4, 0, 23, 0, 0);
    chk("no_load_23", 64'(tile_loaded), 64'(0));
    repeat (3) begin
      tick();
      chk("stay_load_loaded", 64'(tile_loaded), 64'(0));
      chk("stay_load_tile_start", 64'(tile_start), 64'(0));
      chk("stay_load_busy", 64'(busy), 64'(1));
    end
    chk("push_err_23", 64'(push_err), 64'(0));
    fifo_push_tmp = 1'b1;
    tick();
    chk("loaded_24", 64'(tile_loaded), 64'(1));
    tick();
    fifo_push_tmp = 1'b0;
    chk("push_err_25", 64'(push_err), 64'(1));
    tile_release = 1'b1;
    tick();
    tile_release = 1'b0;

    load_phase(2, 2, 0, 0, 24, 0, 0);
    chk("addr_tile220_first", 64'(first_addr), 64'(160));
    finish_tile(0, 0);
    load_phase(2, 2, 4, 0, 24, 0, 0);
    finish_tile(0, 1);
    tick();
    chk("acks_per_layer", 64'(n_ack), 64'(32));
    chk("tiles_per_layer", 64'(n_ts), 64'(8));
    chk("layer_done_count", 64'(n_ld), 64'(1));
    chk("push_err_sticky", 64'(push_err), 64'(1));

    start = 1'b1;
    tick();
    start = 1'b0;
    load_phase(0, 0, 0, 0, 24, 0, 0);
    finish_tile(0, 0);
    chk("l2_tile_start", 64'(tile_start), 64'(1));
    chk("l2_base_col", 64'(tile_base_col), 64'(4));
    tick();
    chk("l2_rd_req", 64'(rd_req), 64'(1));
    rst = 1'b0;
    #1;
    chk("mid_rst_rd_req", 64'(rd_req), 64'(0));
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_base_col", 64'(tile_base_col), 64'(0));
    chk("mid_rst_push_err", 64'(push_err), 64'(0));
    tick();
    rst = 1'b1;
    repeat (3) tick();
    chk("no_auto_restart_busy", 64'(busy), 64'(0));
    chk("no_auto_restart_req", 64'(rd_req), 64'(0));
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_tile_start", 64'(tile_start), 64'(1));
    chk("restart_bases", 64'({tile_base_n, tile_base_row, tile_base_col}), 64'(0));
    tick();
    chk("restart_rd_req", 64'(rd_req), 64'(1));
    chk("restart_rd_addr", 64'(rd_addr), 64'(100));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
